wb_arbiter: RTL
===============

# wb_arbiter

Two-master Wishbone arbiter that shares one memory-side slave port between two bus masters, typically the instruction-cache and data-cache fill/flush ports. Holds a grant for the full duration of the winner's `cyc` so multi-beat fill and flush sequences are never interleaved. Routes the winner's address, data, select, `we` and `stb` to the shared bus, and returns `ack`, `stall` and read data only to the granted master. Sits between the cache back-ends and the SDRAM/memory controller.

## Interface
- `AWIDTH`, 32: address width carried on all three buses.
- `DWIDTH`, 32: data width carried on all three buses.

- `clk_i`  input  1  single clock; all state on rising edge.
- `rst_i`  input  1  reset, asynchronous, active-low.
- `m0`  if_wb.slave  —  requester 0 (icache outbus).
- `m1`  if_wb.slave  —  requester 1 (dcache outbus).
- `outbus`  if_wb.master  —  shared memory bus.
- `grant`  output  2  one-hot current owner; 2'b00 when idle.
- Data ports are accessed through the `NO_MODPORT_EXPRESSIONS` split (`dat_m`/`dat_s` versus `dat_i`/`dat_o`), matching other if_wb users.

## Operation
- State machine `arb_state_t`: A_IDLE, A_GRANT0, A_GRANT1.
- **A_IDLE**
  - No requests: stay.
  - Exactly one of `m0.cyc`/`m1.cyc` high: go to that master's GRANT state.
  - Both high: go to the master that was not last granted.
  - Last-granted pointer `last` resets to 1, so m0 wins the first tie.
- **A_GRANTn**
  - Stay while `mn.cyc` is high.
  - When `mn.cyc` is low: return to A_IDLE and set `last = n`.
- There is exactly one A_IDLE cycle between any two grants. No back-to-back handover.
- **Granted master n:**
  - `outbus.cyc/stb/we/adr/sel/dat_o` equal `mn`'s signals.
  - `mn.ack = outbus.ack`.
  - `mn.stall = outbus.stall`.
  - `mn.dat_i = outbus.dat_i`.
- **Non-granted master:** `ack = 0`, `stall = 1`, read data 0.
- **A_IDLE:**
  - `outbus.cyc = stb = we = 0`, `sel = 0`, `adr = 0`, `dat_o = 0`.
  - Both masters see `stall = 1`, `ack = 0`.
- All outbus and master-side outputs are combinational from the registered state plus the granted master's inputs. They are pure muxing with no added latency inside a grant.
- Addresses pass unmodified, with width `AWIDTH`.

## Timing
- **Reset (rst_i low, asynchronous):**
  - state = A_IDLE, `last` = 1, `grant` = 0.
  - All outbus strobes are 0; all master acks are 0; all master stalls are 1.
- **Request to grant:** a request seen in A_IDLE at edge N gives grant at edge N+1. `outbus.cyc/stb` are visible in cycle N+1. Latency is 1 cycle.
- **Release:** `mn.cyc` low sampled at edge K gives A_IDLE at K+1. The earliest next grant is at K+2.
- **`mn.cyc` dropped while `outbus.ack` is outstanding:** the arbiter drops `outbus.cyc` in the same cycle, which aborts the cycle per Wishbone. The late ack is not forwarded.
- **`mn.stb` low with `cyc` held** (the cache WAIT states): grant is retained and `outbus.stb` = 0.
- **Simultaneous release by n and new request by the other master:** handled as the normal A_IDLE cycle, then grant.
- **Reset asserted mid-grant:** `outbus.cyc` drops immediately (asynchronous). On reset release the arbiter starts in A_IDLE.

## Configuration
- **`WB_ARB_FIXED_PRIORITY_EN` defined:** `last` is not used and m0 always wins ties in A_IDLE. m1 can starve; this is accepted for instruction-fetch-first systems.
- **Undefined (default):** round-robin via `last`, as above. Neither master waits more than one competing grant.

## Structure
- **Package `wb_arb_pkg`:**
  - typedef `arb_state_t` (`bit [1:0]`).
  - localparam `NUM_MASTERS = 2`.
  - function `arb_pick(req[1:0], last)` returning the one-hot winner, with the fixed-priority variant selected by the macro.
- **Sub-modules:** none. The output muxing is small and stays in the top module.

## Test plan
1. **Reset defaults:** assert `rst_i` low for 3 cycles with both `cyc` high → `grant = 00`, `outbus.cyc = 0`, `m0.stall = m1.stall = 1`. Release reset → `grant = 01` one cycle later.
2. **Single master burst:** m1 issues a 4-beat fill (`adr` 0x100, 0x104, 0x108, 0x10C), slave acks each after 2 cycles → `outbus.adr` follows m1, m1 receives 4 acks with matching data, m0 sees no ack.
3. **Tie round-robin:**
   - Both request continuously, each holding `cyc` for 5 cycles → grants alternate 01, 10, 01, 10 with one idle cycle between.
   - With `WB_ARB_FIXED_PRIORITY_EN` → always 01.
4. **Held cycle with stb low:** m0 holds `cyc`, drops `stb` for 3 cycles, m1 requests → m1 is not granted until m0 drops `cyc`; `outbus.stb = 0` during the gap.
5. **Abort:** m0 drops `cyc` one cycle before the slave's ack → the ack is not forwarded to m0 or m1; A_IDLE follows.
6. **Mid-grant reset:** assert reset during m1's third beat → `outbus.cyc` falls within the same cycle. After release, m0 wins the next tie (`last` = 1).

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and the winner-selection helper for wb_arbiter.
// Define WB_ARB_FIXED_PRIORITY_EN to make m0 always win ties instead of round-robin.
package wb_arb_pkg;

  localparam int NUM_MASTERS = 2;

  typedef enum bit [1:0] {
    A_IDLE   = 2'd0,
    A_GRANT0 = 2'd1,
    A_GRANT1 = 2'd2
  } arb_state_t;

  // One-hot winner among the requesters; last is the index of the previous owner.
  function automatic logic [NUM_MASTERS-1:0] arb_pick(input logic [NUM_MASTERS-1:0] req,
                                                      input logic last);
`ifdef WB_ARB_FIXED_PRIORITY_EN
    arb_pick = {req[1] & ~req[0], req[0]} | {NUM_MASTERS{1'b0 & last}};
`else
    if (req == 2'b11) arb_pick = last ? 2'b01 : 2'b10;
    else              arb_pick = req;
`endif
  endfunction

endpackage

// File: rtl/if_wb.sv
// Pipelined Wishbone bundle. Data is split into dat_m (master to slave) and
// dat_s (slave to master) so users need no modport expressions.
interface if_wb #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              cyc;
  logic              stb;
  logic              we;
  logic [AWIDTH-1:0] adr;
  logic [DWIDTH/8-1:0] sel;
  logic [DWIDTH-1:0] dat_m;
  logic [DWIDTH-1:0] dat_s;
  logic              ack;
  logic              stall;

  modport master (output cyc, stb, we, adr, sel, dat_m, input ack, stall, dat_s);
  modport slave  (input cyc, stb, we, adr, sel, dat_m, output ack, stall, dat_s);
endinterface

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter; grant is held for the winner's whole cyc.
// Tie policy is round-robin unless WB_ARB_FIXED_PRIORITY_EN is defined.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  if_wb.slave                    m0,
  if_wb.slave                    m1,
  if_wb.master                   outbus,
  output logic [NUM_MASTERS-1:0] grant
);

  arb_state_t              state, state_nxt;
  logic                    last;
  logic [NUM_MASTERS-1:0]  pick;

  logic                    cyc_mux, stb_mux, we_mux;
  logic [AWIDTH-1:0]       adr_mux;
  logic [DWIDTH/8-1:0]     sel_mux;
  logic [DWIDTH-1:0]       dat_mux;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= A_IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == A_GRANT0 && !m0.cyc) last <= 1'b0;
      if (state == A_GRANT1 && !m1.cyc) last <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    pick      = arb_pick({m1.cyc, m0.cyc}, last);
    case (state)
      A_IDLE: begin
        if (pick[0])      state_nxt = A_GRANT0;
        else if (pick[1]) state_nxt = A_GRANT1;
      end
      A_GRANT0: if (!m0.cyc) state_nxt = A_IDLE;
      A_GRANT1: if (!m1.cyc) state_nxt = A_IDLE;
      default:  state_nxt = A_IDLE;
    endcase
  end

  // Pure muxing off the registered owner; ack is also gated by the owner's
  // live cyc so an ack racing an abort is never forwarded.
  always_comb begin
    grant    = '0;
    cyc_mux  = 1'b0;
    stb_mux  = 1'b0;
    we_mux   = 1'b0;
    adr_mux  = '0;
    sel_mux  = '0;
    dat_mux  = '0;
    m0.ack   = 1'b0;
    m0.stall = 1'b1;
    m0.dat_s = '0;
    m1.ack   = 1'b0;
    m1.stall = 1'b1;
    m1.dat_s = '0;
    case (state)
      A_GRANT0: begin
        grant    = 2'b01;
        cyc_mux  = m0.cyc;
        stb_mux  = m0.stb;
        we_mux   = m0.we;
        adr_mux  = m0.adr;
        sel_mux  = m0.sel;
        dat_mux  = m0.dat_m;
        m0.ack   = outbus.ack & m0.cyc;
        m0.stall = outbus.stall;
        m0.dat_s = outbus.dat_s;
      end
      A_GRANT1: begin
        grant    = 2'b10;
        cyc_mux  = m1.cyc;
        stb_mux  = m1.stb;
        we_mux   = m1.we;
        adr_mux  = m1.adr;
        sel_mux  = m1.sel;
        dat_mux  = m1.dat_m;
        m1.ack   = outbus.ack & m1.cyc;
        m1.stall = outbus.stall;
        m1.dat_s = outbus.dat_s;
      end
      default: ;
    endcase
  end

  assign outbus.cyc   = cyc_mux;
  assign outbus.stb   = stb_mux;
  assign outbus.we    = we_mux;
  assign outbus.adr   = adr_mux;
  assign outbus.sel   = sel_mux;
  assign outbus.dat_m = dat_mux;

endmodule
